// File: rtl/d_flip_flop_pkg.sv
// rtl/d_flip_flop_pkg.sv - shared control decode and next-state helper for d_flip_flop
package d_flip_flop_pkg;

  localparam int DFF_WIDTH_DEFAULT = 1;
  localparam int DFF_WIDTH_MAX     = 64;

  typedef enum logic [1:0] {
    CLR  = 2'd0,
    SET  = 2'd1,
    LOAD = 2'd2,
    HOLD = 2'd3
  } dff_ctrl_e;

  // Fixed priority: clear beats set beats load.
  function automatic dff_ctrl_e dff_decode(input logic clr, input logic set, input logic en);
    if (clr)
      return CLR;
    else if (set)
      return SET;
    else if (en)
      return LOAD;
    else
      return HOLD;
  endfunction

  function automatic logic [DFF_WIDTH_MAX-1:0] dff_next(
    input dff_ctrl_e                ctrl,
    input logic [DFF_WIDTH_MAX-1:0] q,
    input logic [DFF_WIDTH_MAX-1:0] d,
    input logic [DFF_WIDTH_MAX-1:0] set_value
  );
    case (ctrl)
      CLR:     return '0;
      SET:     return set_value;
      LOAD:    return d;
      default: return q;
    endcase
  endfunction

endpackage

// File: rtl/d_flip_flop_bit.sv
// rtl/d_flip_flop_bit.sv - single storage cell driven by the shared decoded control
module dff_bit
  import d_flip_flop_pkg::*;
#(
  parameter logic RESET_BIT = 1'b0,
  parameter logic SET_BIT   = 1'b1
) (
  input  logic      clk,
  input  logic      rst_n,
  input  dff_ctrl_e ctrl,
  input  logic      d,
  output logic      q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_BIT;
    end else begin
      case (ctrl)
        CLR:     q <= 1'b0;
        SET:     q <= SET_BIT;
        LOAD:    q <= d;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/d_flip_flop.sv
// rtl/d_flip_flop.sv - parameterizable D register with clear/set/load and change flag
module d_flip_flop
  import d_flip_flop_pkg::*;
#(
  parameter int               WIDTH       = DFF_WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [WIDTH-1:0] SET_VALUE   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic             clr,
  input  logic             set,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic             changed
);

  dff_ctrl_e                ctrl;
  logic [DFF_WIDTH_MAX-1:0] q_ext;
  logic [DFF_WIDTH_MAX-1:0] next_ext;

  assign ctrl     = dff_decode(clr, set, en);
  assign q_ext    = DFF_WIDTH_MAX'(q);
  // Upper bits are zero for every control, so a full-width compare equals a WIDTH compare.
  assign next_ext = dff_next(ctrl, q_ext, DFF_WIDTH_MAX'(d), DFF_WIDTH_MAX'(SET_VALUE));

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_bit #(
      .RESET_BIT (RESET_VALUE[i]),
      .SET_BIT   (SET_VALUE[i])
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .ctrl  (ctrl),
      .d     (d[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      changed <= 1'b0;
    else
      changed <= (next_ext != q_ext);
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_d_flip_flop.sv
// tb/tb_d_flip_flop.sv - scoreboard bench for d_flip_flop at widths 8, 1 and 64
module tb_d_flip_flop;

  localparam logic [63:0] RV64 = 64'hDEAD_BEEF_0000_FFFF;

  typedef struct {
    string       name;
    int          unit;
    logic [63:0] q;
    logic        ch;
  } exp_t;

  typedef struct {
    int          unit;
    logic        c;
    logic        s;
    logic        e;
    logic [63:0] d;
    string       name;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        c8 = 0, s8 = 0, e8 = 0;
  logic [7:0]  d8 = '0;
  logic [7:0]  q8, qn8;
  logic        ch8;
  logic        c1 = 0, s1 = 0, e1 = 0;
  logic        d1 = 0;
  logic        q1, qn1, ch1;
  logic        c64 = 0, s64 = 0, e64 = 0;
  logic [63:0] d64 = '0;
  logic [63:0] q64, qn64;
  logic        ch64;

  d_flip_flop #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .d(d8), .en(e8), .clr(c8), .set(s8),
    .q(q8), .q_n(qn8), .changed(ch8)
  );

  d_flip_flop #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .d(d1), .en(e1), .clr(c1), .set(s1),
    .q(q1), .q_n(qn1), .changed(ch1)
  );

  d_flip_flop #(.WIDTH(64), .RESET_VALUE(RV64)) u_w64 (
    .clk(clk), .rst_n(rst_n), .d(d64), .en(e64), .clr(c64), .set(s64),
    .q(q64), .q_n(qn64), .changed(ch64)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [63:0] m_q[3];

  function automatic logic [63:0] mask(int u);
    case (u)
      0:       return 64'hFF;
      1:       return 64'h1;
      default: return '1;
    endcase
  endfunction

  function automatic logic [63:0] rst_val(int u);
    return (u == 2) ? RV64 : 64'h0;
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 3; u++) m_q[u] = rst_val(u);
  endtask

  task automatic rd(input int u, output logic [63:0] aq, output logic [63:0] aqn, output logic ach);
    case (u)
      0:       begin aq = {56'h0, q8};  aqn = {56'h0, qn8};  ach = ch8;  end
      1:       begin aq = {63'h0, q1};  aqn = {63'h0, qn1};  ach = ch1;  end
      default: begin aq = q64;          aqn = qn64;          ach = ch64; end
    endcase
  endtask

  // Drives one unit's controls (others idle) and pushes the reference result.
  task automatic apply(input stim_t st);
    logic [63:0] nx;
    c8 = 0; s8 = 0; e8 = 0; c1 = 0; s1 = 0; e1 = 0; c64 = 0; s64 = 0; e64 = 0;
    case (st.unit)
      0:       begin c8 = st.c;  s8 = st.s;  e8 = st.e;  d8 = st.d[7:0]; end
      1:       begin c1 = st.c;  s1 = st.s;  e1 = st.e;  d1 = st.d[0];   end
      default: begin c64 = st.c; s64 = st.s; e64 = st.e; d64 = st.d;     end
    endcase
    if (st.c)      nx = 64'h0;
    else if (st.s) nx = mask(st.unit);
    else if (st.e) nx = st.d & mask(st.unit);
    else           nx = m_q[st.unit];
    sb.push_back('{name: st.name, unit: st.unit, q: nx, ch: (nx != m_q[st.unit])});
    m_q[st.unit] = nx;
  endtask

  task automatic test_reset();
    logic [63:0] aq, aqn;
    logic        ach;
    #1 rst_n = 1'b0;
    c8 = 1'($urandom); s8 = 1'($urandom); e8 = 1'($urandom); d8 = 8'($urandom);
    model_reset();
    #1;
    for (int u = 0; u < 3; u++) begin
      rd(u, aq, aqn, ach);
      checks++;
      if (aq !== rst_val(u) || aqn !== (~rst_val(u) & mask(u)) || ach !== 1'b0) begin
        errors++;
        $display("FAIL reset_async unit%0d: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=0",
                 u, aq, aqn, ach, rst_val(u), ~rst_val(u) & mask(u));
      end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      c8 = 1'($urandom); s8 = 1'($urandom); e8 = 1'($urandom); d8 = 8'($urandom);
      c64 = 1'($urandom); s64 = 1'($urandom); e64 = 1'($urandom); d64 = {$urandom, $urandom};
      @(posedge clk); #1;
      checks++;
      if (q8 !== 8'h00 || ch8 !== 1'b0 || q64 !== RV64 || qn64 !== ~RV64) begin
        errors++;
        $display("FAIL reset_held: q8=%h ch8=%b q64=%h qn64=%h, want 00 0 %h %h",
                 q8, ch8, q64, qn64, RV64, ~RV64);
      end
    end
    @(negedge clk);
    apply('{unit: 0, c: 0, s: 0, e: 0, d: 64'h5A, name: "release_hold"});
    rst_n = 1'b1;
    @(posedge clk); #1;
    begin
      exp_t ex;
      ex = sb.pop_front();
      rd(ex.unit, aq, aqn, ach);
      checks++;
      if (aq !== ex.q || aqn !== (~ex.q & mask(ex.unit)) || ach !== ex.ch) begin
        errors++;
        $display("FAIL %s: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=%b",
                 ex.name, aq, aqn, ach, ex.q, ~ex.q & mask(ex.unit), ex.ch);
      end
    end
  endtask

  task automatic test_load_hold();
    stim_t       st[$];
    exp_t        ex;
    logic [63:0] aq, aqn;
    logic        ach;
    st.push_back('{unit: 0, c: 0, s: 0, e: 1, d: 64'hA5, name: "load_a5"});
    st.push_back('{unit: 0, c: 0, s: 0, e: 0, d: 64'hFF, name: "hold_ff"});
    st.push_back('{unit: 0, c: 0, s: 0, e: 0, d: 'x,     name: "hold_x"});
    foreach (st[i]) begin
      @(negedge clk); apply(st[i]);
      @(posedge clk); #1;
      ex = sb.pop_front();
      rd(ex.unit, aq, aqn, ach);
      checks++;
      if (aq !== ex.q || aqn !== (~ex.q & mask(ex.unit)) || ach !== ex.ch) begin
        errors++;
        $display("FAIL %s: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=%b",
                 ex.name, aq, aqn, ach, ex.q, ~ex.q & mask(ex.unit), ex.ch);
      end
    end
  endtask

  task automatic test_priority_change();
    stim_t       st[$];
    exp_t        ex;
    logic [63:0] aq, aqn;
    logic        ach;
    st.push_back('{unit: 0, c: 1, s: 1, e: 1, d: 64'h3C, name: "clr_set_en"});
    st.push_back('{unit: 0, c: 0, s: 1, e: 1, d: 64'h00, name: "set_en"});
    st.push_back('{unit: 0, c: 0, s: 0, e: 1, d: 64'h11, name: "load_11_first"});
    st.push_back('{unit: 0, c: 0, s: 0, e: 1, d: 64'h11, name: "load_11_again"});
    st.push_back('{unit: 0, c: 1, s: 0, e: 0, d: 64'h00, name: "clr_nonzero"});
    st.push_back('{unit: 0, c: 1, s: 0, e: 1, d: 64'h99, name: "clr_at_zero"});
    foreach (st[i]) begin
      @(negedge clk); apply(st[i]);
      @(posedge clk); #1;
      ex = sb.pop_front();
      rd(ex.unit, aq, aqn, ach);
      checks++;
      if (aq !== ex.q || aqn !== (~ex.q & mask(ex.unit)) || ach !== ex.ch) begin
        errors++;
        $display("FAIL %s: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=%b",
                 ex.name, aq, aqn, ach, ex.q, ~ex.q & mask(ex.unit), ex.ch);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t        ex;
    logic [63:0] aq, aqn;
    logic        ach;
    @(negedge clk); apply('{unit: 0, c: 0, s: 0, e: 1, d: 64'h22, name: "preload_22"});
    @(posedge clk); #1;
    void'(sb.pop_front());
    @(negedge clk);
    e8 = 1'b1; d8 = 8'h77;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (q8 !== 8'h00 || qn8 !== 8'hFF || ch8 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: q=%h q_n=%h changed=%b, want 00 ff 0", q8, qn8, ch8);
    end
    @(posedge clk); #1;
    checks++;
    if (q8 !== 8'h00) begin
      errors++;
      $display("FAIL mid_reset_no_capture: q=%h, want 00", q8);
    end
    @(negedge clk);
    apply('{unit: 0, c: 0, s: 0, e: 1, d: 64'h77, name: "reload_77"});
    rst_n = 1'b1;
    @(posedge clk); #1;
    ex = sb.pop_front();
    rd(ex.unit, aq, aqn, ach);
    checks++;
    if (aq !== ex.q || aqn !== (~ex.q & mask(ex.unit)) || ach !== ex.ch) begin
      errors++;
      $display("FAIL %s: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=%b",
               ex.name, aq, aqn, ach, ex.q, ~ex.q & mask(ex.unit), ex.ch);
    end
  endtask

  task automatic test_params();
    stim_t       st[$];
    exp_t        ex;
    logic [63:0] aq, aqn;
    logic        ach;
    st.push_back('{unit: 1, c: 0, s: 0, e: 1, d: 64'h1, name: "w1_load1"});
    st.push_back('{unit: 1, c: 0, s: 0, e: 1, d: 64'h0, name: "w1_load0"});
    st.push_back('{unit: 1, c: 0, s: 1, e: 0, d: 64'h0, name: "w1_set"});
    st.push_back('{unit: 1, c: 1, s: 0, e: 1, d: 64'h1, name: "w1_clr"});
    st.push_back('{unit: 1, c: 1, s: 0, e: 0, d: 64'h0, name: "w1_clr_zero"});
    st.push_back('{unit: 2, c: 0, s: 0, e: 0, d: 64'h0, name: "w64_hold_reset"});
    st.push_back('{unit: 2, c: 0, s: 0, e: 1, d: 64'h0123_4567_89AB_CDEF, name: "w64_load"});
    st.push_back('{unit: 2, c: 1, s: 0, e: 0, d: 64'h0, name: "w64_clr"});
    st.push_back('{unit: 2, c: 0, s: 1, e: 0, d: 64'h0, name: "w64_set"});
    st.push_back('{unit: 2, c: 0, s: 0, e: 1, d: ~RV64, name: "w64_load_inv"});
    foreach (st[i]) begin
      @(negedge clk); apply(st[i]);
      @(posedge clk); #1;
      ex = sb.pop_front();
      rd(ex.unit, aq, aqn, ach);
      checks++;
      if (aq !== ex.q || aqn !== (~ex.q & mask(ex.unit)) || ach !== ex.ch) begin
        errors++;
        $display("FAIL %s: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=%b",
                 ex.name, aq, aqn, ach, ex.q, ~ex.q & mask(ex.unit), ex.ch);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t        ex;
    logic [63:0] aq, aqn;
    logic        ach;
    int          r;
    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      @(negedge clk);
      apply('{unit: (k % 3 == 2) ? 2 : 0, c: (r == 0), s: (r == 1), e: (r > 4),
              d: {$urandom, $urandom_range(0, 3)}, name: "random_op"});
      @(posedge clk); #1;
      ex = sb.pop_front();
      rd(ex.unit, aq, aqn, ach);
      checks++;
      if (aq !== ex.q || aqn !== (~ex.q & mask(ex.unit)) || ach !== ex.ch) begin
        errors++;
        $display("FAIL %s[%0d]: q=%h q_n=%h changed=%b, want q=%h q_n=%h changed=%b",
                 ex.name, k, aq, aqn, ach, ex.q, ~ex.q & mask(ex.unit), ex.ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_hold();
    test_priority_change();
    test_mid_reset();
    test_params();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
